gb_cart_mapper: RTL and testbench
=================================

Name: gb_cart_mapper

Overview:
Parametrised cartridge-side memory mapper between the CPU bus and the cartridge ROM, boot ROM and external RAM arrays. Successor to the fixed 32 KiB synchronous ROM model. Adds:
- MBC1-style ROM/RAM bank switching.
- A sticky boot-ROM overlay disable at 0xFF50.
- Registered read data with a valid strobe.
- Open-bus 0xFF for disabled RAM.

Parameters:
ROM_BANKS, 2, number of 16 KiB ROM banks; power of two, 2..128
RAM_BANKS, 0, number of 8 KiB external RAM banks; 0, 1 or 4
BOOT_EN, 1, 1 = boot ROM overlays 0x0000-0x00FF out of reset; 0 = overlay never active
ROM_AW, $clog2(ROM_BANKS)+14, derived ROM address width (localparam)
RAM_AW, max(1,$clog2(max(RAM_BANKS,1))+13), derived RAM address width (localparam)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset; synchronous, active-high
cpu_addr  in  16  CPU bus address
cpu_wdata  in  8  CPU write data
cpu_rd  in  1  read request, single-cycle strobe
cpu_wr  in  1  write request, single-cycle strobe
cpu_rdata  out  8  read data, valid when cpu_rvalid
cpu_rvalid  out  1  read response strobe
rom_addr  out  ROM_AW  ROM array address (array has 1-cycle sync read)
rom_data  in  8  ROM array data, one cycle after rom_addr
boot_addr  out  8  boot ROM address (= cpu_addr[7:0])
boot_data  in  8  boot ROM data, one cycle after boot_addr
ram_addr  out  RAM_AW  external RAM address
ram_wdata  out  8  external RAM write data (= cpu_wdata)
ram_we  out  1  external RAM write enable
ram_rdata  in  8  external RAM data, one cycle after ram_addr
boot_active  out  1  boot overlay currently mapped

Behaviour:
- Reset values:
  - Outputs: cpu_rvalid=0, cpu_rdata=0x00, ram_we=0, boot_active=BOOT_EN.
  - Registers: ram_en=0, bank_lo=5'd1, bank_hi=2'd0, mode=0.
  - rst overrides any cpu_rd/cpu_wr in the same cycle.
  - An in-flight read is dropped: cpu_rvalid=0 in the cycle after rst.
- Decode regions:
  - ROM0 = 0x0000-0x3FFF
  - ROMX = 0x4000-0x7FFF
  - ERAM = 0xA000-0xBFFF
  - BOOTREG = 0xFF50
  - All other addresses are ignored: no write effect, no cpu_rvalid.
- Reads:
  - cpu_rd in cycle N on a decoded region → cpu_rvalid=1 and cpu_rdata valid in cycle N+1 only.
  - The source select is registered in cycle N. Array addresses are combinational from cpu_addr and the bank registers in cycle N.
  - Back-to-back reads every cycle are supported.
- Source select:
  - Boot ROM if boot_active and cpu_addr<0x0100.
  - Else ROM for ROM0/ROMX.
  - ERAM: RAM data if ram_en and RAM_BANKS>0, else 0xFF.
  - BOOTREG: 0xFE | ~boot_active.
- ROM mapping:
  - ROM0: bank = mode ? {bank_hi,5'b0} : 0.
  - ROMX: bank = {bank_hi,bank_lo}.
  - Bank number is masked to ROM_BANKS-1 (wrap).
  - rom_addr = {bank_masked, cpu_addr[13:0]}.
- RAM mapping:
  - ram_addr = {(mode && RAM_BANKS==4) ? bank_hi : 0, cpu_addr[12:0]}, truncated to RAM_AW.
- Writes (cpu_wr, take effect next cycle):
  - 0x0000-0x1FFF: ram_en = (cpu_wdata[3:0]==4'hA).
  - 0x2000-0x3FFF: bank_lo = cpu_wdata[4:0]; a value of 0 is stored as 1. Masking to ROM_BANKS happens at use, not at store.
  - 0x4000-0x5FFF: bank_hi = cpu_wdata[1:0].
  - 0x6000-0x7FFF: mode = cpu_wdata[0].
  - ERAM: ram_we=1 in the same cycle, combinational, only if ram_en and RAM_BANKS>0; otherwise dropped.
  - BOOTREG: any nonzero value clears boot_active. It is sticky until rst; writing 0 has no effect.
- Simultaneous cpu_rd and cpu_wr: the write is performed, the read is discarded, no cpu_rvalid.
- Changing a bank register in cycle N affects reads issued in N+1 onward. A read in flight returns data from the old mapping.

Decomposition:
- Package gb_mem_pkg holds:
  - Region base/limit constants (ROM0, ROMX, ERAM, BOOTREG, MBC register windows).
  - Region enum typedef: REG_NONE, REG_BOOT, REG_ROM, REG_ERAM, REG_BREG.
  - BOOT_SIZE = 256.
  - OPEN_BUS = 8'hFF.
- Sub-module gb_mbc1_regs holds the control registers, write decode and bank-number computation. Top level keeps the read pipeline and data mux.

Test Plan:
- Boot overlay: after rst, read 0x0000 → cpu_rvalid in the next cycle with boot_data. Write 0xFF50=0x01, read 0x0000 → rom_data from rom_addr 0x0000, boot_active=0. A subsequent write 0xFF50=0x00 leaves boot_active=0.
- Bank select, ROM_BANKS=8:
  - Write 0x2000=0x00, read 0x4123 → rom_addr=0x04123 (bank 1).
  - Write 0x2000=0x0B, read 0x4123 → rom_addr=0x0C123 (11 masked to 3).
- Mode 1, ROM_BANKS=128:
  - Write 0x4000=0x02, 0x6000=0x01, read 0x0010 → rom_addr=0x100010.
  - Write 0x6000=0x00, same read → rom_addr=0x000010.
- RAM gating, RAM_BANKS=4:
  - Read 0xA000 with ram_en=0 → 0xFF, ram_we stays 0 on write.
  - Write 0x0000=0x0A, mode=1, bank_hi=3, write 0xA005=0x5A → ram_we=1 with ram_addr=0x6005. A later read of 0xA005 returns ram_rdata.
- Pipeline/reset:
  - Reads on 0x0100, 0x0101, 0x0102 in consecutive cycles → three consecutive rvalid pulses in order.
  - rst asserted in the cycle after a read → no rvalid, all registers back to reset values.
  - Read of 0x8000 → no rvalid.

Source files
------------

// File: rtl/gb_mem_pkg.sv
// Shared address map, region encoding and constants for the cartridge mapper.
// Imported by the MBC1 control registers and the mapper top level.
package gb_mem_pkg;

    localparam logic [15:0] ROM0_BASE    = 16'h0000;
    localparam logic [15:0] ROM0_LIMIT   = 16'h3FFF;
    localparam logic [15:0] ROMX_BASE    = 16'h4000;
    localparam logic [15:0] ROMX_LIMIT   = 16'h7FFF;
    localparam logic [15:0] ERAM_BASE    = 16'hA000;
    localparam logic [15:0] ERAM_LIMIT   = 16'hBFFF;
    localparam logic [15:0] BOOTREG_ADDR = 16'hFF50;

    // MBC1 register windows overlay the ROM address space on writes.
    localparam logic [15:0] RAMEN_BASE   = 16'h0000;
    localparam logic [15:0] RAMEN_LIMIT  = 16'h1FFF;
    localparam logic [15:0] BANKLO_BASE  = 16'h2000;
    localparam logic [15:0] BANKLO_LIMIT = 16'h3FFF;
    localparam logic [15:0] BANKHI_BASE  = 16'h4000;
    localparam logic [15:0] BANKHI_LIMIT = 16'h5FFF;
    localparam logic [15:0] MODE_BASE    = 16'h6000;
    localparam logic [15:0] MODE_LIMIT   = 16'h7FFF;

    localparam int          BOOT_SIZE = 256;
    localparam logic [7:0]  OPEN_BUS  = 8'hFF;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_BOOT,
        REG_ROM,
        REG_ERAM,
        REG_BREG
    } region_t;

    function automatic logic in_range(input logic [15:0] a, input logic [15:0] lo,
                                      input logic [15:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

endpackage

// File: rtl/gb_mbc1_regs.sv
// MBC1 control registers: write decode, sticky boot-overlay disable and the
// bank numbers presented to the ROM/RAM address paths.
module gb_mbc1_regs
    import gb_mem_pkg::*;
#(
    parameter int ROM_BANKS = 2,
    parameter int RAM_BANKS = 0,
    parameter int BOOT_EN   = 1,
    parameter int ROM_BW    = $clog2(ROM_BANKS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       cpu_addr,
    input  logic [7:0]        cpu_wdata,
    input  logic              cpu_wr,
    output logic [ROM_BW-1:0] rom0_bank,
    output logic [ROM_BW-1:0] romx_bank,
    output logic [1:0]        ram_bank,
    output logic              ram_en,
    output logic              ram_we,
    output logic              boot_active
);

    localparam bit HAS_RAM   = (RAM_BANKS > 0);
    localparam bit RAM_BANK4 = (RAM_BANKS == 4);

    logic [4:0] bank_lo;
    logic [1:0] bank_hi;
    logic       mode;

    always_ff @(posedge clk) begin
        if (rst) begin
            ram_en      <= 1'b0;
            bank_lo     <= 5'd1;
            bank_hi     <= 2'd0;
            mode        <= 1'b0;
            boot_active <= (BOOT_EN != 0);
        end else if (cpu_wr) begin
            if (in_range(cpu_addr, RAMEN_BASE, RAMEN_LIMIT)) begin
                ram_en <= (cpu_wdata[3:0] == 4'hA);
            end else if (in_range(cpu_addr, BANKLO_BASE, BANKLO_LIMIT)) begin
                // Bank 0 is not selectable in the switchable window.
                bank_lo <= (cpu_wdata[4:0] == 5'd0) ? 5'd1 : cpu_wdata[4:0];
            end else if (in_range(cpu_addr, BANKHI_BASE, BANKHI_LIMIT)) begin
                bank_hi <= cpu_wdata[1:0];
            end else if (in_range(cpu_addr, MODE_BASE, MODE_LIMIT)) begin
                mode <= cpu_wdata[0];
            end else if ((cpu_addr == BOOTREG_ADDR) && (cpu_wdata != 8'h00)) begin
                boot_active <= 1'b0;
            end
        end
    end

    // Truncation to ROM_BW bits is the wrap to ROM_BANKS (a power of two).
    always_comb begin
        romx_bank = ROM_BW'({bank_hi, bank_lo});
        rom0_bank = mode ? ROM_BW'({bank_hi, 5'b00000}) : '0;
        ram_bank  = (mode && RAM_BANK4) ? bank_hi : 2'b00;
        ram_we    = !rst && cpu_wr && in_range(cpu_addr, ERAM_BASE, ERAM_LIMIT)
                    && ram_en && HAS_RAM;
    end

endmodule

// File: rtl/gb_cart_mapper.sv
// Cartridge-side memory mapper: region decode, array addressing and the
// registered read-data pipeline in front of ROM, boot ROM and external RAM.
module gb_cart_mapper
    import gb_mem_pkg::*;
#(
    parameter  int ROM_BANKS = 2,
    parameter  int RAM_BANKS = 0,
    parameter  int BOOT_EN   = 1,
    localparam int ROM_BW    = $clog2(ROM_BANKS),
    localparam int ROM_AW    = ROM_BW + 14,
    localparam int RAM_AW    = $clog2((RAM_BANKS > 1) ? RAM_BANKS : 1) + 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       cpu_addr,
    input  logic [7:0]        cpu_wdata,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_rvalid,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [7:0]        boot_addr,
    input  logic [7:0]        boot_data,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              ram_we,
    input  logic [7:0]        ram_rdata,
    output logic              boot_active
);

    localparam bit HAS_RAM = (RAM_BANKS > 0);

    logic [ROM_BW-1:0] rom0_bank;
    logic [ROM_BW-1:0] romx_bank;
    logic [1:0]        ram_bank;
    logic              ram_en;
    region_t           region;
    region_t           sel_d;
    region_t           sel_q;
    logic [7:0]        const_d;
    logic [7:0]        const_q;
    logic              rd_fire;
    logic              rvalid_q;

    gb_mbc1_regs #(
        .ROM_BANKS (ROM_BANKS),
        .RAM_BANKS (RAM_BANKS),
        .BOOT_EN   (BOOT_EN),
        .ROM_BW    (ROM_BW)
    ) u_regs (
        .clk         (clk),
        .rst         (rst),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_wr      (cpu_wr),
        .rom0_bank   (rom0_bank),
        .romx_bank   (romx_bank),
        .ram_bank    (ram_bank),
        .ram_en      (ram_en),
        .ram_we      (ram_we),
        .boot_active (boot_active)
    );

    always_comb begin
        rom_addr  = {(cpu_addr[14] ? romx_bank : rom0_bank), cpu_addr[13:0]};
        ram_addr  = RAM_AW'({ram_bank, cpu_addr[12:0]});
        boot_addr = cpu_addr[7:0];
        ram_wdata = cpu_wdata;
    end

    always_comb begin
        region = REG_NONE;
        if (boot_active && (cpu_addr < 16'(BOOT_SIZE))) begin
            region = REG_BOOT;
        end else if (in_range(cpu_addr, ROM0_BASE, ROMX_LIMIT)) begin
            region = REG_ROM;
        end else if (in_range(cpu_addr, ERAM_BASE, ERAM_LIMIT)) begin
            region = REG_ERAM;
        end else if (cpu_addr == BOOTREG_ADDR) begin
            region = REG_BREG;
        end
    end

    // Read handshake: cpu_rd is a one-cycle request with no back-pressure.
    // Every decoded read without a concurrent cpu_wr is accepted, and
    // cpu_rvalid pulses for exactly one cycle on the following cycle.
    always_comb begin
        rd_fire = cpu_rd && !cpu_wr && (region != REG_NONE);
        sel_d   = region;
        if ((region == REG_ERAM) && !(ram_en && HAS_RAM)) begin
            sel_d = REG_NONE;
        end
        const_d = (region == REG_BREG) ? (8'hFE | {7'b0000000, ~boot_active}) : OPEN_BUS;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            sel_q    <= REG_NONE;
            const_q  <= OPEN_BUS;
        end else begin
            rvalid_q <= rd_fire;
            if (rd_fire) begin
                sel_q   <= sel_d;
                const_q <= const_d;
            end
        end
    end

    // Array data arrives in the response cycle, so the mux sits after the regs.
    always_comb begin
        cpu_rvalid = rvalid_q;
        cpu_rdata  = 8'h00;
        if (rvalid_q) begin
            case (sel_q)
                REG_BOOT: cpu_rdata = boot_data;
                REG_ROM:  cpu_rdata = rom_data;
                REG_ERAM: cpu_rdata = ram_rdata;
                default:  cpu_rdata = const_q;
            endcase
        end
    end

endmodule

// File: tb/tb_gb_cart_mapper.sv
// Bench for gb_cart_mapper: two instances (8 and 128 ROM banks, 4 RAM banks)
// on shared stimulus, directed vector table plus randomized cycles vs a model.
module tb_gb_cart_mapper;

    logic        clk;
    logic        rst;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_rd;
    logic        cpu_wr;
    logic        mem_clr;

    logic [7:0]  rdata_a, rdata_b;
    logic        rvalid_a, rvalid_b;
    logic [16:0] rom_addr_a;
    logic [20:0] rom_addr_b;
    logic [7:0]  rom_data_a, rom_data_b;
    logic [7:0]  boot_addr_a, boot_addr_b;
    logic [7:0]  boot_data_a, boot_data_b;
    logic [14:0] ram_addr_a, ram_addr_b;
    logic [7:0]  ram_wdata_a, ram_wdata_b;
    logic        ram_we_a, ram_we_b;
    logic [7:0]  ram_rdata_a, ram_rdata_b;
    logic        boot_active_a, boot_active_b;

    logic [7:0]  ram_a [32768];
    logic [7:0]  ram_b [32768];

    int n_checks = 0;
    int n_errors = 0;

    gb_cart_mapper #(.ROM_BANKS(8), .RAM_BANKS(4), .BOOT_EN(1)) dut_a (
        .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_rdata(rdata_a), .cpu_rvalid(rvalid_a),
        .rom_addr(rom_addr_a), .rom_data(rom_data_a), .boot_addr(boot_addr_a),
        .boot_data(boot_data_a), .ram_addr(ram_addr_a), .ram_wdata(ram_wdata_a),
        .ram_we(ram_we_a), .ram_rdata(ram_rdata_a), .boot_active(boot_active_a)
    );

    gb_cart_mapper #(.ROM_BANKS(128), .RAM_BANKS(4), .BOOT_EN(1)) dut_b (
        .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_rdata(rdata_b), .cpu_rvalid(rvalid_b),
        .rom_addr(rom_addr_b), .rom_data(rom_data_b), .boot_addr(boot_addr_b),
        .boot_data(boot_data_b), .ram_addr(ram_addr_b), .ram_wdata(ram_wdata_b),
        .ram_we(ram_we_b), .ram_rdata(ram_rdata_b), .boot_active(boot_active_b)
    );

    // ---------------- clock / array models ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] rom_fn(input logic [20:0] a);
        return a[7:0] ^ a[15:8] ^ {3'b000, a[20:16]} ^ 8'h3C;
    endfunction

    function automatic logic [7:0] boot_fn(input logic [7:0] a);
        return ~a ^ 8'hA5;
    endfunction

    always @(posedge clk) begin
        rom_data_a  <= rom_fn({4'b0000, rom_addr_a});
        rom_data_b  <= rom_fn(rom_addr_b);
        boot_data_a <= boot_fn(boot_addr_a);
        boot_data_b <= boot_fn(boot_addr_b);
        ram_rdata_a <= ram_a[ram_addr_a];
        ram_rdata_b <= ram_b[ram_addr_b];
        if (mem_clr) begin
            for (int i = 0; i < 32768; i++) begin
                ram_a[i] <= 8'h00;
                ram_b[i] <= 8'h00;
            end
        end else begin
            if (ram_we_a) ram_a[ram_addr_a] <= ram_wdata_a;
            if (ram_we_b) ram_b[ram_addr_b] <= ram_wdata_b;
        end
    end

    // ---------------- reference model ----------------
    bit         m_ram_en, m_mode, m_boot;
    int         m_bank_lo, m_bank_hi;
    logic [7:0] model_ram [32768];
    logic [7:0] exp_q_a[$];
    logic [7:0] exp_q_b[$];

    bit          cur_r, cur_wr, pending;
    logic [15:0] cur_a;
    logic [7:0]  cur_d;

    function automatic int exp_rom(input int banks, input logic [15:0] a);
        int bank;
        if (a < 16'h4000) bank = m_mode ? m_bank_hi * 32 : 0;
        else              bank = m_bank_hi * 32 + m_bank_lo;
        return (bank % banks) * 16384 + (int'(a) % 16384);
    endfunction

    function automatic int ram_idx(input logic [15:0] a);
        return (m_mode ? m_bank_hi : 0) * 8192 + (int'(a) % 8192);
    endfunction

    function automatic bit is_eram(input logic [15:0] a);
        return (a >= 16'hA000) && (a <= 16'hBFFF);
    endfunction

    function automatic logic [7:0] exp_read(input int rom_full, input logic [15:0] a);
        logic [7:0] lo;
        lo = a[7:0];
        if (m_boot && a < 16'h0100) return boot_fn(lo);
        if (a < 16'h8000)           return rom_fn(21'(rom_full));
        if (is_eram(a))             return m_ram_en ? model_ram[ram_idx(a)] : 8'hFF;
        return m_boot ? 8'hFE : 8'hFF;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h want %0h (addr %0h)", nm, act, exp, cur_a);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic begin_cycle(input bit r, input logic [15:0] a, input logic [7:0] d,
                               input bit rd_i, input bit wr_i);
        bit decoded;
        int ra, rb;
        rst = r; cpu_addr = a; cpu_wdata = d; cpu_rd = rd_i; cpu_wr = wr_i;
        cur_r = r; cur_a = a; cur_d = d; cur_wr = wr_i;
        #1;
        ra = exp_rom(8, a);
        rb = exp_rom(128, a);
        decoded = (a < 16'h8000) || is_eram(a) || (a == 16'hFF50);
        check("ram_we_a", ram_we_a, !r && wr_i && is_eram(a) && m_ram_en);
        check("ram_we_b", ram_we_b, !r && wr_i && is_eram(a) && m_ram_en);
        if (!r) begin
            check("boot_active_a", boot_active_a, m_boot);
            check("boot_active_b", boot_active_b, m_boot);
            check("boot_addr", boot_addr_a, a[7:0]);
            if (a < 16'h8000) begin
                check("rom_addr_a", rom_addr_a, ra);
                check("rom_addr_b", rom_addr_b, rb);
            end
            if (is_eram(a)) begin
                check("ram_addr_a", ram_addr_a, ram_idx(a));
                check("ram_addr_b", ram_addr_b, ram_idx(a));
                if (wr_i) check("ram_wdata", ram_wdata_a, d);
            end
        end
        pending = !r && rd_i && !wr_i && decoded;
        if (pending) begin
            exp_q_a.push_back(exp_read(ra, a));
            exp_q_b.push_back(exp_read(rb, a));
        end
    endtask

    task automatic end_cycle(input bit chk_resp);
        logic [7:0] ea, eb;
        @(posedge clk);
        if (cur_r) begin
            m_ram_en = 0; m_bank_lo = 1; m_bank_hi = 0; m_mode = 0; m_boot = 1;
        end else if (cur_wr) begin
            if (cur_a < 16'h2000)       m_ram_en = (cur_d[3:0] == 4'hA);
            else if (cur_a < 16'h4000)  m_bank_lo = (cur_d[4:0] == 0) ? 1 : int'(cur_d[4:0]);
            else if (cur_a < 16'h6000)  m_bank_hi = int'(cur_d[1:0]);
            else if (cur_a < 16'h8000)  m_mode = cur_d[0];
            else if (is_eram(cur_a)) begin
                if (m_ram_en) model_ram[ram_idx(cur_a)] = cur_d;
            end else if (cur_a == 16'hFF50 && cur_d != 8'h00) m_boot = 0;
        end
        @(negedge clk);
        if (pending) begin
            ea = exp_q_a.pop_front();
            eb = exp_q_b.pop_front();
        end else begin
            ea = 8'h00;
            eb = 8'h00;
        end
        if (chk_resp) begin
            check("rvalid_a", rvalid_a, pending);
            check("rvalid_b", rvalid_b, pending);
            if (pending) begin
                check("rdata_a", rdata_a, ea);
                check("rdata_b", rdata_b, eb);
            end
        end
    endtask

    task automatic step(input bit r, input logic [15:0] a, input logic [7:0] d,
                        input bit rd_i, input bit wr_i);
        begin_cycle(r, a, d, rd_i, wr_i);
        end_cycle(1'b1);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [15:0] addr;
        logic [7:0]  wdata;
        bit          rd;
        bit          wr;
        bit          chk_rom;
        int          rom_a;
        int          rom_b;
        bit          chk_ram;
        int          ram_a;
        bit          we;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic [15:0] addr, input logic [7:0] wdata,
                                input bit rd, input bit wr, input bit chk_rom,
                                input int rom_a, input int rom_b, input bit chk_ram,
                                input int ram_a, input bit we);
        vec_t v;
        v.addr = addr; v.wdata = wdata; v.rd = rd; v.wr = wr; v.chk_rom = chk_rom;
        v.rom_a = rom_a; v.rom_b = rom_b; v.chk_ram = chk_ram; v.ram_a = ram_a; v.we = we;
        return v;
    endfunction

    initial begin
        bit          r, rd_i, wr_i;
        logic [15:0] a;
        logic [7:0]  d;
        int          sel;

        rst = 1'b1; cpu_addr = '0; cpu_wdata = '0; cpu_rd = 1'b0; cpu_wr = 1'b0;
        mem_clr = 1'b1;
        for (int i = 0; i < 32768; i++) model_ram[i] = 8'h00;
        m_ram_en = 0; m_bank_lo = 1; m_bank_hi = 0; m_mode = 0; m_boot = 1;
        @(negedge clk);
        step(1'b1, 16'h0000, 8'h00, 1'b1, 1'b1);
        mem_clr = 1'b0;
        step(1'b1, 16'h0000, 8'h00, 1'b0, 1'b0);
        check("reset_rdata_a", rdata_a, 8'h00);
        check("reset_rdata_b", rdata_b, 8'h00);
        check("reset_boot_active", boot_active_a, 1'b1);

        vq.push_back(mk(16'h0000, 8'h00, 1, 0, 1, 'h00000, 'h000000, 0, 0, 0));
        vq.push_back(mk(16'hFF50, 8'h01, 0, 1, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(16'h0000, 8'h00, 1, 0, 1, 'h00000, 'h000000, 0, 0, 0));
        vq.push_back(mk(16'hFF50, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(16'hFF50, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(16'h2000, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(16'h4123, 8'h00, 1, 0, 1, 'h04123, 'h004123, 0, 0, 0));
        vq.push_back(mk(16'h2000, 8'h0B, 0, 1, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(16'h4123, 8'h00, 1, 0, 1, 'h0C123, 'h02C123, 0, 0, 0));
        vq.push_back(mk(16'h4000, 8'h02, 0, 1, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(16'h6000, 8'h01, 0, 1, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(16'h0010, 8'h00, 1, 0, 1, 'h00010, 'h100010, 0, 0, 0));
        vq.push_back(mk(16'h4123, 8'h00, 1, 0, 1, 'h0C123, 'h12C123, 0, 0, 0));
        vq.push_back(mk(16'h6000, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(16'h0010, 8'h00, 1, 0, 1, 'h00010, 'h000010, 0, 0, 0));
        vq.push_back(mk(16'hA000, 8'h00, 1, 0, 0, 0, 0, 1, 'h0000, 0));
        vq.push_back(mk(16'hA001, 8'h77, 0, 1, 0, 0, 0, 1, 'h0001, 0));
        vq.push_back(mk(16'h0000, 8'h0A, 0, 1, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(16'h4000, 8'h03, 0, 1, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(16'h6000, 8'h01, 0, 1, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(16'hA005, 8'h5A, 0, 1, 0, 0, 0, 1, 'h6005, 1));
        vq.push_back(mk(16'hA005, 8'h00, 1, 0, 0, 0, 0, 1, 'h6005, 0));
        vq.push_back(mk(16'hA001, 8'h00, 1, 0, 0, 0, 0, 1, 'h6001, 0));
        vq.push_back(mk(16'h0100, 8'h00, 1, 0, 1, 'h00100, 'h180100, 0, 0, 0));
        vq.push_back(mk(16'h0101, 8'h00, 1, 0, 1, 'h00101, 'h180101, 0, 0, 0));
        vq.push_back(mk(16'h0102, 8'h00, 1, 0, 1, 'h00102, 'h180102, 0, 0, 0));
        vq.push_back(mk(16'h8000, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(16'h6000, 8'h00, 1, 1, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(16'h0010, 8'h00, 1, 0, 1, 'h00010, 'h000010, 0, 0, 0));
        vq.push_back(mk(16'h0000, 8'hA0, 0, 1, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(16'hA005, 8'h00, 1, 0, 0, 0, 0, 1, 'h0005, 0));

        foreach (vq[i]) begin
            begin_cycle(1'b0, vq[i].addr, vq[i].wdata, vq[i].rd, vq[i].wr);
            check("tbl_ram_we", ram_we_a, vq[i].we);
            if (vq[i].chk_rom) begin
                check("tbl_rom_addr_a", rom_addr_a, vq[i].rom_a);
                check("tbl_rom_addr_b", rom_addr_b, vq[i].rom_b);
            end
            if (vq[i].chk_ram) check("tbl_ram_addr", ram_addr_b, vq[i].ram_a);
            end_cycle(1'b1);
        end
        check("tbl_boot_sticky", boot_active_a, 1'b0);

        // Reset in the cycle after a read: the read issued with rst is dropped
        // and every control register returns to its reset value.
        step(1'b0, 16'h2000, 8'h05, 1'b0, 1'b1);
        begin_cycle(1'b0, 16'h4123, 8'h00, 1'b1, 1'b0);
        end_cycle(1'b0);
        step(1'b1, 16'h4123, 8'h00, 1'b1, 1'b0);
        check("rst_rvalid", rvalid_a, 1'b0);
        check("rst_rdata", rdata_a, 8'h00);
        check("rst_boot_active", boot_active_b, 1'b1);
        begin_cycle(1'b0, 16'h4123, 8'h00, 1'b1, 1'b0);
        check("rst_bank_lo", rom_addr_b, 21'h004123);
        end_cycle(1'b1);
        begin_cycle(1'b0, 16'hA000, 8'h33, 1'b0, 1'b1);
        check("rst_ram_en", ram_we_a, 1'b0);
        end_cycle(1'b1);
        step(1'b0, 16'h0000, 8'h00, 1'b1, 1'b0);
        step(1'b0, 16'hFF50, 8'h00, 1'b1, 1'b0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            sel  = $urandom_range(0, 9);
            d    = 8'($urandom_range(0, 255));
            case (sel)
                0, 1: begin
                    a = 16'($urandom_range(16'h0000, 16'h1FFF));
                    if ($urandom_range(0, 1) == 1) d = 8'h0A;
                end
                2: a = 16'($urandom_range(16'h2000, 16'h3FFF));
                3: a = 16'($urandom_range(16'h4000, 16'h5FFF));
                4: a = 16'($urandom_range(16'h6000, 16'h7FFF));
                5, 6: a = 16'($urandom_range(16'hA000, 16'hBFFF));
                7: begin
                    a = 16'hFF50;
                    if ($urandom_range(0, 3) != 0) d = 8'h00;
                end
                8: a = 16'($urandom_range(16'h0000, 16'h00FF));
                default: a = 16'($urandom_range(0, 16'hFFFF));
            endcase
            rd_i = ($urandom_range(0, 1) == 1);
            wr_i = ($urandom_range(0, 2) == 0);
            r    = ($urandom_range(0, 63) == 0);
            step(r, a, d, rd_i, wr_i);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
